// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared state encoding and defaults for the tick divider
package clock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } run_state_t;

  localparam int FAST_DIV_DEFAULT = 16;
  localparam int TICK_COUNT_W     = 8;

  // Period counter width for a period of hz cycles, never narrower than one bit.
  function automatic int cnt_width(input int hz);
    return (hz > 2) ? $clog2(hz) : 1;
  endfunction

endpackage

// File: rtl/mod_counter.sv
// rtl/mod_counter.sv - modulo-MOD counter with enable, clear and registered wrap pulse
module mod_counter #(
  parameter int MOD = 60,
  parameter int W   = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         enable,
  input  logic         clear,
  output logic [W-1:0] count,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(MOD - 1);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
      wrap  <= 1'b0;
    end else if (enable) begin
      if (count >= LAST) begin
        count <= '0;
        wrap  <= 1'b1;
      end else begin
        count <= count + W'(1);
        wrap  <= 1'b0;
      end
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule

// File: rtl/tick_divider.sv
// rtl/tick_divider.sv - run/pause period divider producing tick, half_tick and a modulo tick count
module tick_divider
  import clock_pkg::*;
#(
  parameter int HZ       = 27000000,
  parameter int FAST_DIV = FAST_DIV_DEFAULT,
  parameter int SEC_MOD  = 60
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       restart,
  input  logic       fast_mode,
  output logic       tick,
  output logic       half_tick,
  output logic [7:0] tick_count,
  output logic       running
);

  localparam int              CW         = cnt_width(HZ);
  localparam logic [CW-1:0]   LIMIT_NORM = CW'(HZ - 1);
  localparam logic [CW-1:0]   LIMIT_FAST = CW'(HZ / FAST_DIV - 1);

  run_state_t      state;
  run_state_t      state_next;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   limit;
  logic [CW-1:0]   half_point;
  logic            half_done;
  logic            at_limit;
  logic            wrap_en;
  logic            count_wrap_unused;

  // Limit follows fast_mode every cycle; >= lets a shrinking limit wrap at once.
  always_comb begin
    limit      = fast_mode ? LIMIT_FAST : LIMIT_NORM;
    half_point = limit >> 1;
    at_limit   = (cnt >= limit);
    wrap_en    = (state == ST_RUN) && at_limit && !restart;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start && !stop) state_next = ST_RUN;
      ST_RUN:   if (stop)           state_next = ST_PAUSE;
      ST_PAUSE: if (start && !stop) state_next = ST_RUN;
      default:                      state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      running   <= 1'b0;
      cnt       <= '0;
      tick      <= 1'b0;
      half_tick <= 1'b0;
      half_done <= 1'b0;
    end else begin
      state     <= state_next;
      running   <= (state_next == ST_RUN);
      tick      <= 1'b0;
      half_tick <= 1'b0;
      if (restart) begin
        cnt       <= '0;
        half_done <= 1'b0;
      end else if (state == ST_RUN) begin
        if (at_limit) begin
          cnt       <= '0;
          tick      <= 1'b1;
          half_done <= 1'b0;
        end else begin
          cnt <= cnt + CW'(1);
          // half_done keeps a mid-period fast_mode change from firing twice
          if (cnt == half_point && !half_done) begin
            half_tick <= 1'b1;
            half_done <= 1'b1;
          end
        end
      end else if (state == ST_IDLE) begin
        cnt       <= '0;
        half_done <= 1'b0;
      end
    end
  end

  mod_counter #(
    .MOD (SEC_MOD),
    .W   (TICK_COUNT_W)
  ) u_tick_count (
    .clock  (clock),
    .reset  (reset),
    .enable (wrap_en),
    .clear  (restart),
    .count  (tick_count),
    .wrap   (count_wrap_unused)
  );

endmodule

// File: doc/tick_divider.md
TICK_DIVIDER -- requirements
Module: tick_divider

Interface
REQ-001 SHALL have parameter HZ, default 27000000, meaning clock cycles per normal tick period (HZ >= 2).
REQ-002 SHALL have parameter FAST_DIV, default 16, meaning fast-mode divisor (HZ/FAST_DIV >= 2).
REQ-003 SHALL have parameter SEC_MOD, default 60, meaning modulus of the tick counter (2..256).
REQ-004 SHALL have port clock  in  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port start  in  1  level, sampled each edge: begin/resume counting.
REQ-007 SHALL have port stop  in  1  level, sampled each edge: pause counting.
REQ-008 SHALL have port restart  in  1  level: zero period counter and tick count, state unchanged.
REQ-009 SHALL have port fast_mode  in  1  selects period HZ/FAST_DIV (integer division) instead of HZ.
REQ-010 SHALL have port tick  out  1  registered one-cycle pulse per completed period.
REQ-011 SHALL have port half_tick  out  1  registered one-cycle pulse at period midpoint.
REQ-012 SHALL have port tick_count  out  8  registered count of ticks modulo SEC_MOD.
REQ-013 SHALL have port running  out  1  high while state is RUN.

Function
REQ-014 SHALL implement states IDLE, RUN, PAUSE; IDLE->RUN on start; RUN->PAUSE on stop; PAUSE->RUN on start; no transition back to IDLE except by reset.
REQ-015 SHALL give stop priority over start when both are high in the same cycle (RUN stays/becomes PAUSE, IDLE stays IDLE).
REQ-016 SHALL hold period counter cnt (width clog2(HZ)) at 0 in IDLE, frozen in PAUSE, and increment by 1 per clock in RUN.
REQ-017 SHALL define LIMIT = HZ-1 (fast_mode=0) or HZ/FAST_DIV-1 (fast_mode=1), evaluated every cycle.
REQ-018 SHALL, in RUN when cnt >= LIMIT, load cnt with 0 and assert tick on the following cycle.
REQ-019 SHALL therefore produce the first tick exactly period cycles after the edge that sampled start in IDLE, and subsequent ticks every period cycles.
REQ-020 SHALL, on fast_mode switching high while cnt >= new LIMIT, wrap and tick on that cycle per REQ-018 (no counter overflow, no lost tick).
REQ-021 SHALL assert half_tick the cycle after cnt equals LIMIT/2 (integer) in RUN, at most once per period.
REQ-022 SHALL increment tick_count in the same cycle tick is asserted, wrapping SEC_MOD-1 -> 0.
REQ-023 SHALL, on restart, set cnt and tick_count to 0 and suppress tick/half_tick for that cycle; restart overrides any wrap in the same cycle.
REQ-024 SHALL not emit tick or half_tick in IDLE or PAUSE; resume from PAUSE continues from the frozen cnt.
REQ-025 SHALL keep tick and half_tick never high for more than one consecutive cycle.

Reset
REQ-026 SHALL, when reset is high at a rising edge, set state IDLE, cnt 0, tick 0, half_tick 0, tick_count 0, running 0, overriding all other inputs.
REQ-027 SHALL require start after reset deassertion before any tick; reset mid-period discards the partial period.

Structure
REQ-028 SHALL place state encoding (IDLE/RUN/PAUSE) and the FAST_DIV default in shared package clock_pkg.
REQ-029 SHALL instantiate one sub-module mod_counter (parameterised modulus, enable, clear, wrap pulse) for tick_count.
REQ-030 SHALL keep all outputs registered, with no combinational input-to-output path.

Verification (HZ=10, FAST_DIV=2, SEC_MOD=4)
REQ-031 SHALL verify: reset, start one cycle -> first tick 10 cycles after start edge, then every 10; half_tick 5 cycles after each period start; tick_count 1,2,3,0.
REQ-032 SHALL verify: fast_mode=1 while running -> ticks every 5 cycles; fast_mode raised when cnt=7 -> tick next cycle, then period 5.
REQ-033 SHALL verify: stop at cnt=3 for 20 cycles -> no ticks, running=0; start -> next tick 7 cycles later.
REQ-034 SHALL verify: start and stop high together in RUN -> PAUSE; in IDLE -> remains IDLE, running=0.
REQ-035 SHALL verify: restart in the same cycle cnt=9 -> no tick, tick_count=0, next tick 10 cycles later.
REQ-036 SHALL verify: reset at cnt=6 with tick_count=2 -> all outputs 0 next cycle, no tick until start.
